pcp_control_unit: RTL and testbench

//   Multi-cycle fetch/decode/execute sequencer for the PCP processor core.

---
 rtl/pcp_control_unit_pkg.sv | 44 ++++
 rtl/pcp_control_unit_decoder.sv | 54 +++++
 rtl/pcp_control_unit.sv | 140 ++++++++++++++
 tb/tb_pcp_control_unit.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/pcp_control_unit_pkg.sv
// Shared encodings for the PCP control unit: FSM states, opcode values,
// flag bit positions and the one-hot instruction-class bit indices.
package pcp_control_unit_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  localparam logic [5:0] OP_NOP = 6'h00;
  localparam logic [5:0] OP_LDA = 6'h01;
  localparam logic [5:0] OP_STA = 6'h02;
  localparam logic [5:0] OP_PSH = 6'h03;
  localparam logic [5:0] OP_POP = 6'h04;
  localparam logic [5:0] OP_MOV = 6'h05;
  localparam logic [5:0] OP_BRA = 6'h06;
  localparam logic [5:0] OP_BRZ = 6'h07;
  localparam logic [5:0] OP_BRN = 6'h08;
  localparam logic [5:0] OP_BRC = 6'h09;
  localparam logic [5:0] OP_BRO = 6'h0A;
  localparam logic [5:0] OP_HLT = 6'h0B;

  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_O = 0;

  localparam int CL_NOP = 0;
  localparam int CL_LDA = 1;
  localparam int CL_STA = 2;
  localparam int CL_PSH = 3;
  localparam int CL_POP = 4;
  localparam int CL_MOV = 5;
  localparam int CL_BR  = 6;
  localparam int CL_HLT = 7;
  localparam int CL_ALU = 8;
  localparam int CL_ILL = 9;
  localparam int CL_N   = 10;

endpackage

// File: rtl/pcp_control_unit_decoder.sv
// Combinational instruction decode: IR -> one-hot class, ALU function,
// immediate select and branch condition (always-taken or flag mask).
module pcp_control_unit_decoder
  import pcp_control_unit_pkg::*;
#(
  parameter int IR_W     = 16,
  parameter int OP_W     = 6,
  parameter int ALU_OP_W = 5,
  parameter int FLAG_W   = 4
) (
  input  logic [IR_W-1:0]     ir_i,
  output logic [CL_N-1:0]     cls_o,
  output logic [ALU_OP_W-1:0] alu_op_o,
  output logic                imm_o,
  output logic                br_always_o,
  output logic [FLAG_W-1:0]   br_mask_o
);

  logic [OP_W-1:0] op;
  logic            unused_operand;

  assign op             = ir_i[IR_W-1 -: OP_W];
  assign unused_operand = ^ir_i[IR_W-OP_W-2:0];

  always_comb begin
    cls_o       = '0;
    alu_op_o    = '0;
    imm_o       = 1'b0;
    br_always_o = 1'b0;
    br_mask_o   = '0;
    if (op[OP_W-1]) begin
      cls_o[CL_ALU] = 1'b1;
      alu_op_o      = op[ALU_OP_W-1:0];
      imm_o         = ir_i[IR_W-OP_W-1];
    end else begin
      case (op)
        OP_NOP: cls_o[CL_NOP] = 1'b1;
        OP_LDA: cls_o[CL_LDA] = 1'b1;
        OP_STA: cls_o[CL_STA] = 1'b1;
        OP_PSH: cls_o[CL_PSH] = 1'b1;
        OP_POP: cls_o[CL_POP] = 1'b1;
        OP_MOV: cls_o[CL_MOV] = 1'b1;
        OP_BRA: begin cls_o[CL_BR] = 1'b1; br_always_o       = 1'b1; end
        OP_BRZ: begin cls_o[CL_BR] = 1'b1; br_mask_o[FLAG_Z] = 1'b1; end
        OP_BRN: begin cls_o[CL_BR] = 1'b1; br_mask_o[FLAG_N] = 1'b1; end
        OP_BRC: begin cls_o[CL_BR] = 1'b1; br_mask_o[FLAG_C] = 1'b1; end
        OP_BRO: begin cls_o[CL_BR] = 1'b1; br_mask_o[FLAG_O] = 1'b1; end
        OP_HLT: cls_o[CL_HLT] = 1'b1;
        default: cls_o[CL_ILL] = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/pcp_control_unit.sv
// PCP fetch/decode/execute sequencer: FSM, memory-ack timeout, sticky trap
// flags, and datapath strobes decoded from the registered state and IR.
module pcp_control_unit
  import pcp_control_unit_pkg::*;
#(
  parameter int IR_W        = 16,
  parameter int OP_W        = 6,
  parameter int ALU_OP_W    = 5,
  parameter int FLAG_W      = 4,
  parameter int TIMEOUT_CYC = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [IR_W-1:0]     IR,
  input  logic [FLAG_W-1:0]   flags,
  input  logic                mem_ack,
  output logic                fetch,
  output logic                ir_load,
  output logic                PC_increment,
  output logic                bra,
  output logic                hlt,
  output logic                immediate,
  output logic                RD,
  output logic                WR,
  output logic                alu_en,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                psh,
  output logic                pop,
  output logic                mov_en,
  output logic                illegal,
  output logic                bus_err,
  output logic [2:0]          state
);

  localparam int               CNT_W   = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(TIMEOUT_CYC - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               illegal_q, illegal_d;
  logic               bus_err_q, bus_err_d;

  logic [CL_N-1:0]     cls;
  logic [ALU_OP_W-1:0] dec_alu_op;
  logic                dec_imm;
  logic                br_always;
  logic [FLAG_W-1:0]   br_mask;
  logic                in_fetch, in_exec, in_mem;

  pcp_control_unit_decoder #(
    .IR_W     (IR_W),
    .OP_W     (OP_W),
    .ALU_OP_W (ALU_OP_W),
    .FLAG_W   (FLAG_W)
  ) u_dec (
    .ir_i        (IR),
    .cls_o       (cls),
    .alu_op_o    (dec_alu_op),
    .imm_o       (dec_imm),
    .br_always_o (br_always),
    .br_mask_o   (br_mask)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    illegal_d = illegal_q;
    bus_err_d = bus_err_q;
    case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
        cnt_d   = '0;
      end
      S_FETCH, S_MEM: begin
        // An ack arriving on the limit cycle still completes the access.
        if (mem_ack) begin
          state_d = (state_q == S_FETCH) ? S_DECODE : S_FETCH;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LIM) begin
          bus_err_d = 1'b1;
          state_d   = S_HALT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        cnt_d = '0;
        if (cls[CL_LDA] || cls[CL_STA]) begin
          state_d = S_MEM;
        end else if (cls[CL_HLT]) begin
          state_d = S_HALT;
        end else if (cls[CL_ILL]) begin
          illegal_d = 1'b1;
          state_d   = S_HALT;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
    end
  end

  assign in_fetch = (state_q == S_FETCH);
  assign in_exec  = (state_q == S_EXEC);
  assign in_mem   = (state_q == S_MEM);

  assign fetch        = in_fetch;
  assign ir_load      = in_fetch & mem_ack;
  assign PC_increment = in_fetch & mem_ack;
  assign RD           = in_fetch | (in_mem & cls[CL_LDA]);
  assign WR           = in_mem & cls[CL_STA];
  assign alu_en       = in_exec & cls[CL_ALU];
  assign alu_op       = alu_en ? dec_alu_op : '0;
  assign immediate    = alu_en & dec_imm;
  assign psh          = in_exec & cls[CL_PSH];
  assign pop          = in_exec & cls[CL_POP];
  assign mov_en       = in_exec & cls[CL_MOV];
  assign bra          = in_exec & cls[CL_BR] & (br_always | (|(flags & br_mask)));
  assign hlt          = (state_q == S_HALT);
  assign illegal      = illegal_q;
  assign bus_err      = bus_err_q;
  assign state        = state_q;

endmodule

// File: tb/tb_pcp_control_unit.sv
// Instruction-level reference bench for pcp_control_unit: each instruction is
// expanded into its expected per-cycle strobe trace and compared every cycle.
module tb_pcp_control_unit;

  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] IR;
  logic [3:0]  flags;
  logic        mem_ack;
  logic        fetch, ir_load, PC_increment, bra, hlt, immediate, RD, WR, alu_en;
  logic [4:0]  alu_op;
  logic        psh, pop, mov_en, illegal, bus_err;
  logic [2:0]  state;

  typedef struct packed {
    logic [2:0] st;
    logic fe, il, pi, br, hl, im, rd, wr, ae;
    logic [4:0] op;
    logic ps, po, mv, ill, be;
  } ov_t;

  ov_t obs;
  int  n_vec = 0;
  int  n_bad = 0;
  logic ill_s, berr_s;
  bit   halted;

  pcp_control_unit #(
    .IR_W(16), .OP_W(6), .ALU_OP_W(5), .FLAG_W(4), .TIMEOUT_CYC(TO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .IR           (IR),
    .flags        (flags),
    .mem_ack      (mem_ack),
    .fetch        (fetch),
    .ir_load      (ir_load),
    .PC_increment (PC_increment),
    .bra          (bra),
    .hlt          (hlt),
    .immediate    (immediate),
    .RD           (RD),
    .WR           (WR),
    .alu_en       (alu_en),
    .alu_op       (alu_op),
    .psh          (psh),
    .pop          (pop),
    .mov_en       (mov_en),
    .illegal      (illegal),
    .bus_err      (bus_err),
    .state        (state)
  );

  always #5 clk = ~clk;

  assign obs = {state, fetch, ir_load, PC_increment, bra, hlt, immediate, RD, WR,
                alu_en, alu_op, psh, pop, mov_en, illegal, bus_err};

  task automatic chk(input string tag, input ov_t got, input ov_t exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [3:0] rf();
    return 4'($urandom);
  endfunction

  function automatic ov_t base(input logic [2:0] st);
    ov_t e;
    e     = '0;
    e.st  = st;
    e.ill = ill_s;
    e.be  = berr_s;
    return e;
  endfunction

  task automatic cyc(input string tag, input logic ack, input logic [3:0] fl,
                     input logic [15:0] ir, input ov_t e);
    @(negedge clk);
    mem_ack = ack;
    flags   = fl;
    IR      = ir;
    #1 chk(tag, obs, e);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst     = 1'b1;
    mem_ack = rb();
    ill_s   = 1'b0;
    berr_s  = 1'b0;
    #1 chk("rst_async", obs, base(3'd0));
    @(negedge clk);
    rst = 1'b0;
    #1 chk("idle", obs, base(3'd0));
  endtask

  task automatic halt_cycles(input logic [15:0] ir);
    ov_t e;
    repeat (3) begin
      e    = base(3'd5);
      e.hl = 1'b1;
      cyc("halt", rb(), rf(), ir, e);
    end
  endtask

  // wf/wm: wait cycles before ack in fetch/memory (>=TO means never acked);
  // abort_at: memory wait cycle at which reset is asserted mid-access (-1 none);
  // efl: flags during execute (-1 random).
  task automatic run_instr(input logic [15:0] ir, input int wf, input int wm,
                           input int abort_at, input int efl, output bit h);
    ov_t         e;
    logic [3:0]  fl;
    logic [5:0]  op;
    logic [15:0] old;
    op  = ir[15:10];
    old = IR;
    h   = 1'b0;
    for (int i = 0; i < wf && i < TO; i++) begin
      e = base(3'd1); e.fe = 1'b1; e.rd = 1'b1;
      cyc("fetch_wait", 1'b0, rf(), old, e);
    end
    if (wf >= TO) begin
      berr_s = 1'b1;
      halt_cycles(old);
      h = 1'b1;
      return;
    end
    e = base(3'd1); e.fe = 1'b1; e.rd = 1'b1; e.il = 1'b1; e.pi = 1'b1;
    cyc("fetch_ack", 1'b1, rf(), old, e);
    e = base(3'd2);
    cyc("decode", rb(), rf(), ir, e);
    fl = (efl < 0) ? rf() : 4'(efl);
    e  = base(3'd3);
    if (op[5]) begin
      e.ae = 1'b1; e.op = op[4:0]; e.im = ir[9];
    end else begin
      case (op)
        6'd3:  e.ps = 1'b1;
        6'd4:  e.po = 1'b1;
        6'd5:  e.mv = 1'b1;
        6'd6:  e.br = 1'b1;
        6'd7:  e.br = fl[3];
        6'd8:  e.br = fl[2];
        6'd9:  e.br = fl[1];
        6'd10: e.br = fl[0];
        default: ;
      endcase
    end
    cyc("exec", rb(), fl, ir, e);
    if (!op[5] && op >= 6'd11) begin
      if (op != 6'd11) ill_s = 1'b1;
      halt_cycles(ir);
      h = 1'b1;
      return;
    end
    if (op == 6'd1 || op == 6'd2) begin
      for (int i = 0; i < wm && i < TO; i++) begin
        if (i == abort_at) begin
          @(negedge clk);
          mem_ack = 1'b0;
          #2 rst  = 1'b1;
          ill_s   = 1'b0;
          berr_s  = 1'b0;
          #1 chk("rst_mid_mem", obs, base(3'd0));
          h = 1'b1;
          return;
        end
        e = base(3'd4); e.rd = (op == 6'd1); e.wr = (op == 6'd2);
        cyc("mem_wait", 1'b0, rf(), ir, e);
      end
      if (wm >= TO) begin
        berr_s = 1'b1;
        halt_cycles(ir);
        h = 1'b1;
        return;
      end
      e = base(3'd4); e.rd = (op == 6'd1); e.wr = (op == 6'd2);
      cyc("mem_ack", 1'b1, rf(), ir, e);
    end
  endtask

  task automatic go(input logic [15:0] ir, input int wf, input int wm,
                    input int ab, input int efl);
    run_instr(ir, wf, wm, ab, efl, halted);
    if (halted) do_reset();
  endtask

  function automatic int rwait();
    int r;
    r = $urandom_range(0, 99);
    if (r < 4)  return TO + $urandom_range(0, 2);
    if (r < 10) return TO - 1;
    return $urandom_range(0, 3);
  endfunction

  initial begin
    logic [5:0] op;
    int         r;
    rst = 1'b1; IR = '0; flags = '0; mem_ack = 1'b0;
    ill_s = 1'b0; berr_s = 1'b0;
    do_reset();

    go(16'h8500, 0, 0, -1, -1);      // ADD register form
    go(16'h1C00, 0, 0, -1, 8);       // BRZ, Z set
    go(16'h1C00, 1, 0, -1, 0);       // BRZ, Z clear
    go(16'h0400, 0, 4, -1, -1);      // LDA, 4 wait states
    go(16'h0800, 2, TO - 1, -1, -1); // STA, ack on the limit cycle
    go(16'h0000, TO, 0, -1, -1);     // fetch timeout
    go(16'h3000, 0, 0, -1, -1);      // illegal 0x0C
    go(16'h0400, 0, 10, 2, -1);      // reset mid-MEM
    go(16'h2C00, 0, 0, -1, -1);      // HLT

    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 99);
      if (r < 35)      op = {1'b1, 5'($urandom)};
      else if (r < 90) op = 6'($urandom_range(0, 10));
      else if (r < 94) op = 6'd11;
      else             op = 6'($urandom_range(12, 31));
      go({op, 10'($urandom)}, rwait(), rwait(),
         ($urandom_range(0, 19) == 0) ? $urandom_range(0, 3) : -1, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
